// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, bit counter, ACK levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } i2c_state_e;

    localparam int unsigned BIT_CNT_W = 4;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
    localparam bit_cnt_t BITS_PER_BYTE = 4'd8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer, optional glitch filter (I2C_GLITCH_FILTER_EN), edge detect.
module i2c_line_filter #(
    parameter int unsigned FILTER_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;

    if (FILTER_DEPTH == 0) begin : g_depth_check
        $error("FILTER_DEPTH must be at least 1");
    end

    // Reset to the idle-bus level so release from reset produces no edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (sync_q[1] == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(FILTER_DEPTH - 1)) begin
            filt_q <= sync_q[1];
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with fixed 7-bit address; byte-wide write delivery and read sourcing.
// Optional input glitch filter selected by defining I2C_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDRESS = 7'h4D,
    parameter int unsigned FILTER_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_taken,
    output logic       read_mode,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    i2c_state_e state_q;
    bit_cnt_t   bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] tx_shift_q;
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       tx_taken_q;
    logic       read_mode_q;
    logic       busy_q;

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filt (
        .clk    (clk),
        .reset  (reset),
        .line_i (scl),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filt (
        .clk    (clk),
        .reset  (reset),
        .line_i (sda),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_taken_q  <= 1'b0;
            read_mode_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_taken_q <= 1'b0;
            if (start_cond) begin
                state_q     <= ADDR;
                bit_cnt_q   <= '0;
                shift_q     <= '0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
                read_mode_q <= 1'b0;
            end else if (stop_cond) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    // Address and write data share the shift-in path; the byte end differs.
                    ADDR, WR_BYTE: begin
                        if (scl_rise && bit_cnt_q != BITS_PER_BYTE) begin
                            shift_q   <= {shift_q[6:0], sda_lvl};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                            bit_cnt_q <= '0;
                            if (state_q == WR_BYTE) begin
                                sda_oe_q   <= 1'b1;
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                                state_q    <= WR_ACK;
                            end else if (shift_q[7:1] == TARGET_ADDRESS) begin
                                sda_oe_q    <= 1'b1;
                                read_mode_q <= shift_q[0];
                                state_q     <= ADDR_ACK;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            busy_q <= 1'b1;
                            if (read_mode_q) begin
                                tx_shift_q <= {tx_data[6:0], 1'b0};
                                sda_oe_q   <= ~tx_data[7];
                                tx_taken_q <= 1'b1;
                                bit_cnt_q  <= 4'd1;
                                state_q    <= RD_BYTE;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= WR_BYTE;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= WR_BYTE;
                        end
                    end
                    // bit_cnt_q counts bits already placed on the bus.
                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == BITS_PER_BYTE) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= RD_ACK;
                            end else begin
                                sda_oe_q   <= ~tx_shift_q[7];
                                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                                bit_cnt_q  <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && sda_lvl == I2C_NACK) begin
                            busy_q  <= 1'b0;
                            state_q <= IGNORE;
                        end else if (scl_fall) begin
                            tx_shift_q <= {tx_data[6:0], 1'b0};
                            sda_oe_q   <= ~tx_data[7];
                            tx_taken_q <= 1'b1;
                            bit_cnt_q  <= 4'd1;
                            state_q    <= RD_BYTE;
                        end
                    end
                    IDLE, IGNORE: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_taken  = tx_taken_q;
    assign read_mode = read_mode_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: write vector table plus read, repeated START, reset and filter sequences.
module tb_i2c_target;

    localparam int unsigned Q = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda_bus;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_taken;
    logic       read_mode;
    logic       busy;

    pullup (sda_bus);
    assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;

    i2c_target #(.TARGET_ADDRESS(7'h4D), .FILTER_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda_bus),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_taken (tx_taken),
        .read_mode(read_mode),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    int unsigned rx_cnt = 0;
    int unsigned tx_cnt = 0;
    int unsigned drv_cnt = 0;
    logic [7:0]  rx_log [64];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[5:0]] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (tx_taken) tx_cnt = tx_cnt + 1;
        if (sda_bus === 1'b0 && !sda_drv_low) drv_cnt = drv_cnt + 1;
    end

    int unsigned total = 0;
    int unsigned passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_drv_low = ~b;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        s = sda_bus;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic bus_start();
        sda_drv_low = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic bus_rstart();
        sda_drv_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        sda_drv_low = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic bus_stop();
        sda_drv_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        sda_drv_low = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
        bit_xfer(ack_bit, s);
    endtask

    typedef struct {
        logic [7:0]  addr_byte;
        int unsigned nbytes;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        exp_ack;
    } wr_vec_t;

    wr_vec_t vecs [4];

    initial begin
        logic        ack;
        logic [7:0]  d;
        logic [7:0]  dv;
        int unsigned rx_base, tx_base, drv_base;

        vecs[0] = '{addr_byte: 8'h9A, nbytes: 2, d0: 8'hAA, d1: 8'h55, exp_ack: 1'b1};
        vecs[1] = '{addr_byte: 8'h9C, nbytes: 1, d0: 8'hFF, d1: 8'h00, exp_ack: 1'b0};
        vecs[2] = '{addr_byte: 8'h00, nbytes: 1, d0: 8'h12, d1: 8'h00, exp_ack: 1'b0};
        vecs[3] = '{addr_byte: 8'h9A, nbytes: 2, d0: 8'h00, d1: 8'hFF, exp_ack: 1'b1};

        wait_clks(5);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_taken", 32'(tx_taken), 32'd0);
        check("rst_read_mode", 32'(read_mode), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_sda", 32'(sda_bus), 32'd1);
        reset = 1'b1;
        wait_clks(10);

        for (int v = 0; v < 4; v++) begin
            rx_base  = rx_cnt;
            drv_base = drv_cnt;
            bus_start();
            send_byte(vecs[v].addr_byte, ack);
            check($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(!vecs[v].exp_ack));
            for (int j = 0; j < int'(vecs[v].nbytes); j++) begin
                dv = (j == 0) ? vecs[v].d0 : vecs[v].d1;
                send_byte(dv, ack);
                check($sformatf("v%0d_data%0d_ack", v, j), 32'(ack), 32'(!vecs[v].exp_ack));
            end
            check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_ack));
            check($sformatf("v%0d_read_mode", v), 32'(read_mode), 32'd0);
            bus_stop();
            wait_clks(8);
            check($sformatf("v%0d_busy_after_stop", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_rx_count", v), rx_cnt - rx_base,
                  vecs[v].exp_ack ? vecs[v].nbytes : 32'd0);
            if (vecs[v].exp_ack) begin
                check($sformatf("v%0d_rx0", v), 32'(rx_log[rx_base[5:0]]), 32'(vecs[v].d0));
                check($sformatf("v%0d_rx1", v), 32'(rx_log[6'(rx_base + 1)]), 32'(vecs[v].d1));
            end else begin
                check($sformatf("v%0d_no_drive", v), drv_cnt - drv_base, 32'd0);
            end
        end

        // Read: 3C then C3; tx_data changed mid-byte must not disturb byte 1.
        rx_base = rx_cnt;
        tx_base = tx_cnt;
        tx_data = 8'h3C;
        bus_start();
        send_byte(8'h9B, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        check("rd_taken1", tx_cnt - tx_base, 32'd1);
        check("rd_read_mode", 32'(read_mode), 32'd1);
        check("rd_busy", 32'(busy), 32'd1);
        tx_data = 8'hC3;
        recv_byte(1'b0, d);
        check("rd_byte1", 32'(d), 32'h3C);
        recv_byte(1'b1, d);
        check("rd_byte2", 32'(d), 32'hC3);
        check("rd_taken2", tx_cnt - tx_base, 32'd2);
        wait_clks(4);
        check("rd_busy_after_nack", 32'(busy), 32'd0);
        check("rd_sda_released", 32'(sda_bus), 32'd1);
        check("rd_no_rx_valid", rx_cnt - rx_base, 32'd0);
        bus_stop();
        wait_clks(8);

        // Repeated START after a partial write byte.
        rx_base = rx_cnt;
        tx_data = 8'hA5;
        bus_start();
        send_byte(8'h9A, ack);
        check("rs_wr_ack", 32'(ack), 32'd0);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b0, ack);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b1, ack);
        bus_rstart();
        check("rs_busy_dropped", 32'(busy), 32'd0);
        send_byte(8'h9B, ack);
        check("rs_rd_ack", 32'(ack), 32'd0);
        check("rs_read_mode", 32'(read_mode), 32'd1);
        recv_byte(1'b1, d);
        check("rs_rd_byte", 32'(d), 32'hA5);
        check("rs_no_rx_valid", rx_cnt - rx_base, 32'd0);
        bus_stop();
        wait_clks(8);

        // Asynchronous reset while the address ACK is being driven.
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            dv = 8'h9A;
            bit_xfer(dv[i], ack);
        end
        sda_drv_low = 1'b0;
        wait_clks(2);
        check("ar_ack_driven", 32'(sda_bus), 32'd0);
        reset = 1'b0;
        #1;
        check("ar_sda_released", 32'(sda_bus), 32'd1);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_rx_data", 32'(rx_data), 32'd0);
        check("ar_read_mode", 32'(read_mode), 32'd0);
        check("ar_pulses", 32'({rx_valid, tx_taken}), 32'd0);
        wait_clks(3);
        reset = 1'b1;
        wait_clks(5);
        scl = 1'b1;
        wait_clks(Q);
        rx_base = rx_cnt;
        bus_start();
        send_byte(8'h9A, ack);
        check("ar_post_addr_ack", 32'(ack), 32'd0);
        send_byte(8'h3E, ack);
        check("ar_post_data_ack", 32'(ack), 32'd0);
        bus_stop();
        wait_clks(8);
        check("ar_post_rx_count", rx_cnt - rx_base, 32'd1);
        check("ar_post_rx_data", 32'(rx_log[rx_base[5:0]]), 32'h3E);

`ifdef I2C_GLITCH_FILTER_EN
        // 2-clk low glitch with scl high is filtered out; the following address is not ACKed.
        sda_drv_low = 1'b1;
        wait_clks(2);
        sda_drv_low = 1'b0;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
        send_byte(8'h9A, ack);
        check("gf_short_no_start", 32'(ack), 32'd1);
        check("gf_short_busy", 32'(busy), 32'd0);
        bus_stop();
        wait_clks(8);
        // 6-clk low before scl falls is long enough to register as START.
        sda_drv_low = 1'b1;
        wait_clks(6);
        scl = 1'b0;
        wait_clks(Q);
        send_byte(8'h9A, ack);
        check("gf_long_start", 32'(ack), 32'd0);
        bus_stop();
        wait_clks(8);
        check("gf_busy_after_stop", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
